// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the lsu_wb load/store unit.
// Size encodings, FSM state encoding, byte-select and alignment functions.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Reserved size 2'b11 behaves as a word everywhere.
  function automatic logic [3:0] lsu_sel(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] sel;
    case (size)
      SZ_BYTE: sel = 4'b0001 << addr_lo;
      SZ_HALF: sel = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_wb_if.sv
// Wishbone B4 classic bus bundle between the LSU (master) and memory (slave).
interface lsu_wb_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] adr_o;
  logic [31:0]       dat_o;
  logic [3:0]        sel_o;
  logic              we_o;
  logic              cyc_o;
  logic              stb_o;
  logic [31:0]       dat_i;
  logic              ack_i;
  logic              err_i;

  modport master (
    output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication / byte selects and
// load lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_sel,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_unsigned,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  always_comb begin
    o_st_sel = lsu_sel(i_st_size, i_st_addr_lo);
    case (i_st_size)
      SZ_BYTE: o_st_wdata = {4{i_st_wdata[7:0]}};
      SZ_HALF: o_st_wdata = {2{i_st_wdata[15:0]}};
      default: o_st_wdata = i_st_wdata;
    endcase
  end

  always_comb begin
    w_ld_byte = i_ld_raw[{i_ld_addr_lo, 3'b000} +: 8];
    w_ld_half = i_ld_raw[{i_ld_addr_lo[1], 4'b0000} +: 16];
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{w_ld_byte[7] & ~i_ld_unsigned}}, w_ld_byte};
      SZ_HALF: o_ld_data = {{16{w_ld_half[15] & ~i_ld_unsigned}}, w_ld_half};
      default: o_ld_data = i_ld_raw;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// Load/store unit running one Wishbone B4 classic cycle per MEM request.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for an unkilled request
// BUS     | cyc/stb asserted, waiting for ack/err (or watchdog)
// RESP    | one-cycle response slot; mem_ack_o unless killed
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic              kill_i,
  output logic [31:0]       rdata_o,
  output logic              mem_ack_o,
  output logic              misaligned_o,
  output logic              bus_err_o,
  output logic              busy_o,
  lsu_wb_if.master          wbm
);

  lsu_state_e        r_state, w_state_nxt;
  logic [1:0]        r_size, w_size_nxt;
  logic              r_unsigned, w_unsigned_nxt;
  logic [1:0]        r_addr_lo, w_addr_lo_nxt;
  logic              r_killed, w_killed_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic              r_mem_ack, w_mem_ack_nxt;
  logic              r_misal, w_misal_nxt;
  logic              r_bus_err, w_bus_err_nxt;
  logic              r_busy, w_busy_nxt;
  logic [ADDR_W-1:0] r_adr, w_adr_nxt;
  logic [31:0]       r_dat, w_dat_nxt;
  logic [3:0]        r_sel, w_sel_nxt;
  logic              r_we, w_we_nxt;
  logic              r_cyc, w_cyc_nxt;

  logic [3:0]        w_st_sel;
  logic [31:0]       w_st_wdata;
  logic [31:0]       w_ld_data;
  logic              w_tmo_expire;
  logic              w_kill_seen;

  lsu_align u_align (
    .i_st_size     (req_size_i),
    .i_st_addr_lo  (req_addr_i[1:0]),
    .i_st_wdata    (req_wdata_i),
    .o_st_sel      (w_st_sel),
    .o_st_wdata    (w_st_wdata),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_ld_addr_lo  (r_addr_lo),
    .i_ld_raw      (wbm.dat_i),
    .o_ld_data     (w_ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Down-counter is reloaded whenever we are outside BUS, so it starts fresh on entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if (r_state != ST_BUS) begin
      r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if (r_tmo_cnt != '0) begin
      r_tmo_cnt <= r_tmo_cnt - 1'b1;
    end
  end

  assign w_tmo_expire = (r_state == ST_BUS) && (r_tmo_cnt == '0);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_tmo_expire = 1'b0;
`endif

  assign w_kill_seen = r_killed | kill_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_size_nxt     = r_size;
    w_unsigned_nxt = r_unsigned;
    w_addr_lo_nxt  = r_addr_lo;
    w_killed_nxt   = r_killed;
    w_rdata_nxt    = r_rdata;
    w_mem_ack_nxt  = 1'b0;
    w_misal_nxt    = 1'b0;
    w_bus_err_nxt  = 1'b0;
    w_adr_nxt      = r_adr;
    w_dat_nxt      = r_dat;
    w_sel_nxt      = r_sel;
    w_we_nxt       = r_we;
    w_cyc_nxt      = r_cyc;

    case (r_state)
      ST_IDLE: begin
        if (req_valid_i && !kill_i) begin
          if (lsu_misaligned(req_size_i, req_addr_i[1:0])) begin
            w_state_nxt   = ST_RESP;
            w_mem_ack_nxt = 1'b1;
            w_misal_nxt   = 1'b1;
            w_rdata_nxt   = '0;
          end else begin
            w_state_nxt    = ST_BUS;
            w_size_nxt     = req_size_i;
            w_unsigned_nxt = req_unsigned_i;
            w_addr_lo_nxt  = req_addr_i[1:0];
            w_killed_nxt   = 1'b0;
            w_adr_nxt      = {req_addr_i[ADDR_W-1:2], 2'b00};
            w_dat_nxt      = w_st_wdata;
            w_sel_nxt      = w_st_sel;
            w_we_nxt       = req_we_i;
            w_cyc_nxt      = 1'b1;
          end
        end
      end
      ST_BUS: begin
        w_killed_nxt = w_kill_seen;
        // Priority: err, then ack, then watchdog expiry.
        if (wbm.err_i || wbm.ack_i || w_tmo_expire) begin
          w_state_nxt   = ST_RESP;
          w_cyc_nxt     = 1'b0;
          w_mem_ack_nxt = !w_kill_seen;
          if (wbm.err_i || !wbm.ack_i) begin
            w_bus_err_nxt = !w_kill_seen;
            w_rdata_nxt   = '0;
          end else begin
            w_rdata_nxt = r_we ? 32'h0 : w_ld_data;
          end
        end
      end
      ST_RESP: begin
        w_state_nxt  = ST_IDLE;
        w_killed_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cyc_nxt   = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr_lo  <= '0;
      r_killed   <= 1'b0;
      r_rdata    <= '0;
      r_mem_ack  <= 1'b0;
      r_misal    <= 1'b0;
      r_bus_err  <= 1'b0;
      r_busy     <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_cyc      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_size     <= w_size_nxt;
      r_unsigned <= w_unsigned_nxt;
      r_addr_lo  <= w_addr_lo_nxt;
      r_killed   <= w_killed_nxt;
      r_rdata    <= w_rdata_nxt;
      r_mem_ack  <= w_mem_ack_nxt;
      r_misal    <= w_misal_nxt;
      r_bus_err  <= w_bus_err_nxt;
      r_busy     <= w_busy_nxt;
      r_adr      <= w_adr_nxt;
      r_dat      <= w_dat_nxt;
      r_sel      <= w_sel_nxt;
      r_we       <= w_we_nxt;
      r_cyc      <= w_cyc_nxt;
    end
  end

  assign rdata_o      = r_rdata;
  assign mem_ack_o    = r_mem_ack;
  assign misaligned_o = r_misal;
  assign bus_err_o    = r_bus_err;
  assign busy_o       = r_busy;
  assign wbm.adr_o    = r_adr;
  assign wbm.dat_o    = r_dat;
  assign wbm.sel_o    = r_sel;
  assign wbm.we_o     = r_we;
  assign wbm.cyc_o    = r_cyc;
  assign wbm.stb_o    = r_cyc;

endmodule

// File: tb/tb_lsu_wb.sv
// Directed testbench for lsu_wb: vector table plus kill/reset/watchdog sequences.
// Define LSU_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_lsu_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        kill = 1'b0;
  logic [31:0] rdata;
  logic        mem_ack, misal, bus_err, busy;

  int errors = 0;
  int checks = 0;

  lsu_wb_if #(.ADDR_W(32)) bus ();

  lsu_wb #(.ADDR_W(32), .TIMEOUT_CYCLES(255)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .kill_i         (kill),
    .rdata_o        (rdata),
    .mem_ack_o      (mem_ack),
    .misaligned_o   (misal),
    .bus_err_o      (bus_err),
    .busy_o         (busy),
    .wbm            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          waits;
    int          resp;     // 0 ack, 1 err, 2 ack+err together
    logic [3:0]  e_sel;
    logic [31:0] e_dat;
    logic [31:0] e_rdata;
    logic        e_mis;
    logic        e_err;
    int          e_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, stb_n;
    logic [31:0] rd, adr0, dat0;
    logic [3:0] sel0;
    logic mis, be, we0, unstable;
    lat = 0; stb_n = 0; unstable = 1'b0;
    rd = '0; adr0 = '0; dat0 = '0; sel0 = '0; mis = 1'b0; be = 1'b0; we0 = 1'b0;
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    bus.dat_i = v.sdata;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      bus.ack_i = 1'b0; bus.err_i = 1'b0;
      if (bus.cyc_o && bus.stb_o) begin
        if (stb_n == 0) begin
          adr0 = bus.adr_o; dat0 = bus.dat_o; sel0 = bus.sel_o; we0 = bus.we_o;
        end else if (bus.adr_o !== adr0 || bus.dat_o !== dat0 || bus.sel_o !== sel0 || bus.we_o !== we0) begin
          unstable = 1'b1;
        end
        stb_n++;
        if (stb_n > v.waits) begin
          if (v.resp != 0) bus.err_i = 1'b1;
          if (v.resp != 1) bus.ack_i = 1'b1;
        end
      end
      if (mem_ack) begin
        lat = k; rd = rdata; mis = misal; be = bus_err;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check({v.name, " latency"}, 32'(lat), 32'(v.e_lat));
    check({v.name, " rdata"}, rd, v.e_rdata);
    check({v.name, " misaligned"}, {31'b0, mis}, {31'b0, v.e_mis});
    check({v.name, " bus_err"}, {31'b0, be}, {31'b0, v.e_err});
    if (v.e_mis) begin
      check({v.name, " stb_cycles"}, 32'(stb_n), 32'd0);
    end else begin
      check({v.name, " stb_cycles"}, 32'(stb_n), 32'(v.waits + 1));
      check({v.name, " sel"}, {28'b0, sel0}, {28'b0, v.e_sel});
      check({v.name, " dat_o"}, dat0, v.e_dat);
      check({v.name, " adr_o"}, adr0, v.addr & 32'hFFFF_FFFC);
      check({v.name, " we_o"}, {31'b0, we0}, {31'b0, v.we});
      check({v.name, " bus_stable"}, {31'b0, unstable}, 32'd0);
    end
    @(negedge clk);
    check({v.name, " ack_one_cycle"}, {31'b0, mem_ack}, 32'd0);
    check({v.name, " busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  vec_t vecs[$];
  vec_t err_vec;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int stb_n, acks, lat;
    logic be;
    bus.dat_i = '0; bus.ack_i = 1'b0; bus.err_i = 1'b0;

    //        name     we   size   uns  addr          wdata          sdata          w  r  sel      dat            rdata          mis  err  lat
    vecs.push_back('{"LW100",  0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0, 2});
    vecs.push_back('{"LB103",  0, 2'b00, 0, 32'h103, 32'h0,        32'h80112233, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 0, 2});
    vecs.push_back('{"LBU103", 0, 2'b00, 1, 32'h103, 32'h0,        32'h80112233, 0, 0, 4'b1000, 32'h0,        32'h00000080, 0, 0, 2});
    vecs.push_back('{"SH102",  1, 2'b01, 0, 32'h102, 32'h0000ABCD, 32'h0,        3, 0, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0, 5});
    vecs.push_back('{"LW101",  0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 0, 1});
    vecs.push_back('{"LH102",  0, 2'b01, 0, 32'h102, 32'h0,        32'h80011234, 0, 0, 4'b1100, 32'h0,        32'hFFFF8001, 0, 0, 2});
    vecs.push_back('{"LHU100", 0, 2'b01, 1, 32'h100, 32'h0,        32'h8001F234, 1, 0, 4'b0011, 32'h0,        32'h0000F234, 0, 0, 3});
    vecs.push_back('{"SB101",  1, 2'b00, 0, 32'h101, 32'h123456A5, 32'h0,        1, 0, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0, 3});
    vecs.push_back('{"SB100",  1, 2'b00, 0, 32'h100, 32'h0000003C, 32'h0,        0, 0, 4'b0001, 32'h3C3C3C3C, 32'h0,        0, 0, 2});
    vecs.push_back('{"SW204",  1, 2'b10, 0, 32'h204, 32'h12345678, 32'hFFFFFFFF, 0, 0, 4'b1111, 32'h12345678, 32'h0,        0, 0, 2});
    vecs.push_back('{"LH101",  0, 2'b01, 0, 32'h101, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1, 0, 1});
    vecs.push_back('{"LB102",  0, 2'b00, 0, 32'h102, 32'h0,        32'h007F0000, 0, 0, 4'b0100, 32'h0,        32'h0000007F, 0, 0, 2});
    vecs.push_back('{"LWERR",  0, 2'b10, 0, 32'h108, 32'h0,        32'h55555555, 0, 1, 4'b1111, 32'h0,        32'h0,        0, 1, 2});
    vecs.push_back('{"LWRSV",  0, 2'b11, 0, 32'h10C, 32'h0,        32'hCAFEF00D, 0, 0, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 0, 2});
    vecs.push_back('{"LWBOTH", 0, 2'b10, 0, 32'h110, 32'h0,        32'h11111111, 2, 2, 4'b1111, 32'h0,        32'h0,        0, 1, 4});
    err_vec = '{"LWERR2", 0, 2'b10, 0, 32'h120, 32'h0, 32'h77777777, 1, 1, 4'b1111, 32'h0, 32'h0, 0, 1, 3};

    #12;
    check("reset cyc", {31'b0, bus.cyc_o}, 32'd0);
    check("reset outputs", {rdata[30:0] | bus.dat_o[30:0] | bus.adr_o[30:0], rdata[31]}, 32'd0);
    check("reset flags", {26'b0, mem_ack, misal, bus_err, busy, bus.we_o, bus.stb_o}, 32'd0);
    check("reset sel", {28'b0, bus.sel_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Kill in IDLE discards the request.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h200; req_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    check("kill_idle cyc", {31'b0, bus.cyc_o}, 32'd0);
    check("kill_idle busy", {31'b0, busy}, 32'd0);
    req_valid = 1'b0; kill = 1'b0;

    // Kill during BUS: the bus cycle finishes but no mem_ack is issued.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h300; req_valid = 1'b1;
    bus.dat_i = 32'h0BADF00D;
    stb_n = 0; acks = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.ack_i = 1'b0;
      kill = (k == 1);
      if (k == 1) req_valid = 1'b0;
      if (bus.cyc_o && bus.stb_o) begin
        stb_n++;
        if (stb_n > 2) bus.ack_i = 1'b1;
      end
      if (mem_ack) acks++;
    end
    check("kill_bus stb_cycles", 32'(stb_n), 32'd3);
    check("kill_bus mem_ack", 32'(acks), 32'd0);
    check("kill_bus busy", {31'b0, busy}, 32'd0);
    run_vec(err_vec);

    // Reset mid-BUS drops cyc/stb immediately with no ack.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h400; req_valid = 1'b1;
    @(negedge clk);
    check("rst_bus stb_before", {31'b0, bus.stb_o}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_bus cyc_async", {31'b0, bus.cyc_o}, 32'd0);
    check("rst_bus stb_async", {31'b0, bus.stb_o}, 32'd0);
    check("rst_bus busy_async", {31'b0, busy}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_ack || bus.cyc_o) acks++;
    end
    check("rst_bus no_ack", 32'(acks), 32'd0);

`ifdef LSU_TIMEOUT_EN
    // Silent slave: the watchdog ends the cycle as a bus error after 255 cycles.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h500; req_valid = 1'b1;
    stb_n = 0; lat = 0; be = 1'b0;
    for (int k = 1; k <= 400 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.cyc_o && bus.stb_o) stb_n++;
      if (mem_ack) begin
        lat = k; be = bus_err; req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("timeout stb_cycles", 32'(stb_n), 32'd255);
    check("timeout latency", 32'(lat), 32'd256);
    check("timeout bus_err", {31'b0, be}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Load/store unit: the memory-side producer of the MEM-stage load data and the `mem_ack` handshake that the forwarding/stall logic consumes.
- Accepts one load or store per request from the MEM stage and runs a single Wishbone B4 classic master cycle.
- Performs byte-lane steering and sign/zero extension on loads.
- Returns the result with a one-cycle `mem_ack_o` pulse, or reports a misaligned access or bus error instead of a result.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 255, bus watchdog limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  MEM stage requests an access
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
- req_unsigned_i  in  1  zero-extend load (LBU/LHU)
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  32  store data, right-aligned
- kill_i  in  1  pipeline flush
- rdata_o  out  32  extended load data (feeds MEM_dat)
- mem_ack_o  out  1  one-cycle completion pulse
- misaligned_o  out  1  valid with mem_ack_o
- bus_err_o  out  1  valid with mem_ack_o
- busy_o  out  1  transaction in flight
- wbm_adr_o  out  ADDR_W  word-aligned address, [1:0] = 0
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte selects
- wbm_we_o  out  1  write enable
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  ack
- wbm_err_i  in  1  error

Behaviour:
- Clocking and reset:
  - One clock, `clk_i`; reset `rst_i` is asynchronous and active-high.
  - Reset forces every output to 0 and the state to IDLE.
  - Reset mid-transaction drops `cyc`/`stb` immediately; the pending request is lost and no `mem_ack_o` is issued.
- All outputs are registered.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Samples `req_valid_i` only when `kill_i` = 0; `kill_i` = 1 in IDLE discards the request.
  - Misaligned request (half with addr[0] = 1, or word with addr[1:0] != 0): go to RESP with `misaligned_o` = 1. No bus cycle.
  - Aligned request: latch size, unsigned, addr[1:0] and we; drive `adr`/`dat`/`sel`/`we`; assert `cyc` = `stb` = 1 at the next edge; go to BUS.
- Store lane rules:
  - byte: `wbm_sel_o` = 1 << addr[1:0]; data byte replicated 4x.
  - half: `wbm_sel_o` = 0011 or 1100; data half replicated 2x.
  - word: `wbm_sel_o` = 1111.
- Load lane rules: `wbm_sel_o` is the same mask as for stores; `wbm_we_o` = 0.
- BUS:
  - `cyc`/`stb` and all bus outputs are held stable until `ack_i` or `err_i`.
  - On `ack_i`: drop `cyc`/`stb` at that edge, register the extracted and extended load data (stores: `rdata_o` = 0), go to RESP.
  - On `err_i`: drop `cyc`/`stb`, set `bus_err_o` = 1, `rdata_o` = 0, go to RESP.
  - `ack_i` and `err_i` together: err wins.
  - `kill_i` in BUS does not abort the bus cycle. It sets a sticky `killed` flag; RESP then suppresses `mem_ack_o` and clears the flag.
- RESP:
  - `mem_ack_o` = 1 for exactly one cycle unless `killed`; return to IDLE.
  - `misaligned_o`/`bus_err_o` are meaningful only while `mem_ack_o` = 1 and are 0 otherwise.
  - `rdata_o` holds until the next response.
- Latency: request at cycle N with zero-wait ack gives `stb` at N+1, ack at N+1, `mem_ack_o` at N+2. Each wait state adds one cycle. Misaligned gives `mem_ack_o` at N+1.
- `busy_o` = (state != IDLE). The requester holds its inputs until `mem_ack_o`; new requests are ignored while busy.
- Load extraction: byte/half selected by the latched addr[1:0], then sign-extended, or zero-extended when unsigned.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit or larger counter runs while in BUS and clears on entry.
  - Reaching TIMEOUT_CYCLES without `ack`/`err` drops `cyc`/`stb` and completes as a bus error (`bus_err_o` = 1).
  - An `ack` arriving on the same cycle as expiry wins.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Package `lsu_pkg`:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state encoding.
  - Function computing the `sel` mask from size and addr[1:0].
- Sub-module `lsu_align` (combinational):
  - Store-data replication and sel generation.
  - Load lane extraction and extension.
  - Keeps the FSM module control-only.

Test Plan:
- LW addr 0x100, slave acks at stb cycle with 0xDEADBEEF -> `stb` at N+1, `mem_ack_o` at N+2, `rdata_o` = 0xDEADBEEF, `sel` = 1111.
- LB addr 0x103, data 0x80112233, signed -> `rdata_o` = 0xFFFFFF80; same with LBU -> 0x00000080.
- SH addr 0x102, wdata 0x0000ABCD, 3 wait states -> `sel` = 1100, `dat_o` = 0xABCDABCD held 4 cycles, `mem_ack_o` at N+5.
- LW addr 0x101 -> no `cyc`, `mem_ack_o` and `misaligned_o` = 1 at N+1.
- `kill_i` pulsed during BUS, ack 2 cycles later -> bus cycle completes, no `mem_ack_o`, `busy_o` falls; `err_i` on next load -> `bus_err_o` = 1 with `mem_ack_o`.
- `rst_i` asserted mid-BUS -> `cyc`/`stb` = 0 asynchronously, no ack; with LSU_TIMEOUT_EN and a silent slave -> `bus_err_o` after 255 cycles.
